// File: rtl/mcycle_unit_if.sv
// rtl/mcycle_unit_if.sv - request/result bundle between an issuing pipeline and mcycle_unit
//
// Purpose: groups the operation request (Start, MCycleOp, operands) and the
//          result/stall signals (Result1, Result2, Busy, Done) of mcycle_unit.
// Modports:
//   master - pipeline side: drives Start/MCycleOp/Operand1/Operand2, reads results
//   slave  - mcycle_unit side: reads the request, drives Result1/Result2/Busy/Done
interface mcycle_unit_if;
  logic        Start;
  logic        MCycleOp;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic        Busy;
  logic        Done;

  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result1, Result2, Busy, Done
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result1, Result2, Busy, Done
  );
endinterface

// File: rtl/mcycle_unit.sv
// rtl/mcycle_unit.sv - 32-cycle unsigned shift-add multiplier / restoring divider
//
// Purpose: accepts an operation in IDLE when Start=1, iterates one bit per
//          cycle for 32 cycles in COMPUTE, then shows the results with a
//          one-cycle Done pulse in DONE.
// Ports:
//   CLK      in   system clock, rising edge
//   Reset_n  in   asynchronous active-low reset (release synchronized externally)
//   bus      slave modport of mcycle_unit_if:
//            Start, MCycleOp (0 = mul, 1 = div), Operand1, Operand2 in;
//            Result1 (product low / quotient), Result2 (product high /
//            remainder), Busy (stall request), Done (result valid pulse) out
module mcycle_unit (
  input  logic          CLK,
  input  logic          Reset_n,
  mcycle_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic        op_q, op_d;
  // acc holds {product_high, multiplier} for mul and {remainder, dividend/quotient} for div
  logic [63:0] acc_q, acc_d;
  // opnd holds the multiplicand for mul and the divisor for div
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] result1_q, result1_d;
  logic [31:0] result2_q, result2_d;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] iter_next;

  always_comb begin
    // Shift-add: add the multiplicand into the upper half when the multiplier
    // LSB is set; the 33rd sum bit becomes the new MSB after the right shift.
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};

    // Restoring divide: acc_q[63:31] is the remainder after the left shift.
    // It is always below 2*divisor, so bit 32 of the difference is its sign.
    div_diff = acc_q[63:31] - {1'b0, opnd_q};
    div_next = div_diff[32] ? {acc_q[62:0], 1'b0}
                            : {div_diff[31:0], acc_q[30:0], 1'b1};

    iter_next = op_q ? div_next : mul_next;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    result1_d = result1_q;
    result2_d = result2_q;

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          op_d    = bus.MCycleOp;
          acc_d   = {32'd0, bus.MCycleOp ? bus.Operand1 : bus.Operand2};
          opnd_d  = bus.MCycleOp ? bus.Operand2 : bus.Operand1;
          count_d = 5'd0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        acc_d   = iter_next;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d   = DONE;
          result1_d = iter_next[31:0];
          result2_d = iter_next[63:32];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      count_q   <= 5'd0;
      op_q      <= 1'b0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      result1_q <= 32'd0;
      result2_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      result1_q <= result1_d;
      result2_q <= result2_d;
    end
  end

  // Busy is combinational so the PC stalls in the very cycle Start is first
  // seen; gating with Reset_n keeps it low while reset is held.
  assign bus.Busy    = Reset_n & (((state_q == IDLE) & bus.Start) | (state_q == COMPUTE));
  assign bus.Done    = (state_q == DONE);
  assign bus.Result1 = result1_q;
  assign bus.Result2 = result2_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// tb/tb_mcycle_unit.sv - directed scoreboard bench for mcycle_unit
module tb_mcycle_unit;

  logic CLK;
  logic Reset_n;

  mcycle_unit_if bus ();

  mcycle_unit dut (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_r1  = 32'd0;
  logic [31:0] last_r2  = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit multiply, and divide with the divide-by-zero
  // behaviour of a restoring divider (all-ones quotient, dividend remainder).
  function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    if (!op) begin
      p    = 64'(a) * 64'(b);
      e.r1 = p[31:0];
      e.r2 = p[63:32];
    end else if (b == 32'd0) begin
      e.r1 = 32'hFFFF_FFFF;
      e.r2 = a;
    end else begin
      e.r1 = a / b;
      e.r2 = a % b;
    end
    return e;
  endfunction

  // Drives Start for cycle T and checks Busy rises in that same cycle.
  task automatic start_op(input bit no_wait, input logic op, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
    if (!no_wait) @(negedge CLK);
    bus.Start    = 1'b1;
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    sb.push_back(model(op, a, b));
    #1;
    check({tag, "_busy_T"}, 32'(bus.Busy), 32'd1);
    check({tag, "_done_T"}, 32'(bus.Done), 32'd0);
  endtask

  // Follows the operation to its Done pulse, checking latency, Busy length,
  // result hold during COMPUTE and the popped scoreboard entry.
  task automatic finish_op(input bit hold, input bit chg, input string tag);
    int busy_cnt = 1;
    bit seen     = 1'b0;
    exp_t e;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge CLK);
      if (!hold) bus.Start = 1'b0;
      if (chg && cyc == 5) begin
        bus.Operand1 = $urandom;
        bus.Operand2 = $urandom;
        bus.MCycleOp = ~bus.MCycleOp;
      end
      #1;
      if (cyc == 2) begin
        check({tag, "_hold_r1"}, bus.Result1, last_r1);
        check({tag, "_hold_r2"}, bus.Result2, last_r2);
      end
      if (bus.Done) begin
        seen = 1'b1;
        check({tag, "_latency"}, 32'(cyc), 32'd33);
        check({tag, "_busy_in_done"}, 32'(bus.Busy), 32'd0);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
        check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check({tag, "_result1"}, bus.Result1, e.r1);
          check({tag, "_result2"}, bus.Result2, e.r2);
          last_r1 = e.r1;
          last_r2 = e.r2;
        end
      end else if (bus.Busy) begin
        busy_cnt++;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    Reset_n      = 1'b0;
    bus.Start    = 1'b1;
    bus.MCycleOp = 1'b0;
    bus.Operand1 = 32'h1111_1111;
    bus.Operand2 = 32'h2222_2222;
    #12;
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_r1", bus.Result1, 32'd0);
    check("rst_r2", bus.Result2, 32'd0);
    @(negedge CLK);
    bus.Start = 1'b0;
    Reset_n   = 1'b1;

    start_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
    finish_op(1'b0, 1'b0, "mul_max");
    @(negedge CLK);
    #1;
    check("idle_done_low", 32'(bus.Done), 32'd0);
    check("idle_r1_hold", bus.Result1, 32'h0000_0001);
    check("idle_r2_hold", bus.Result2, 32'hFFFF_FFFE);

    start_op(1'b0, 1'b1, 32'd100, 32'd7, "div_100_7");
    finish_op(1'b0, 1'b0, "div_100_7");

    start_op(1'b0, 1'b1, 32'h1234_5678, 32'd0, "div_zero");
    finish_op(1'b0, 1'b0, "div_zero");

    start_op(1'b0, 1'b0, 32'd123456, 32'd654321, "held_a");
    finish_op(1'b1, 1'b0, "held_a");
    start_op(1'b0, 1'b1, 32'hDEAD_BEEF, 32'd1000, "held_b");
    finish_op(1'b0, 1'b0, "held_b");

    start_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, "div_big");
    finish_op(1'b0, 1'b0, "div_big");

    start_op(1'b0, 1'b0, 32'hCAFE_F00D, 32'h0BAD_CAFE, "opchg");
    finish_op(1'b0, 1'b1, "opchg");

    start_op(1'b0, 1'b0, 32'h0000_1234, 32'h0000_5678, "rst_mid");
    sb.delete();
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge CLK);
      bus.Start = 1'b0;
    end
    Reset_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.Busy), 32'd0);
    check("rst_mid_done", 32'(bus.Done), 32'd0);
    check("rst_mid_r1", bus.Result1, 32'd0);
    check("rst_mid_r2", bus.Result2, 32'd0);
    last_r1 = 32'd0;
    last_r2 = 32'd0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge CLK);
      bus.Start = 1'b1;
      #1;
      check("rst_hold_busy", 32'(bus.Busy), 32'd0);
      check("rst_hold_done", 32'(bus.Done), 32'd0);
    end
    @(negedge CLK);
    Reset_n = 1'b1;
    start_op(1'b1, 1'b0, 32'd6, 32'd7, "after_rst");
    finish_op(1'b0, 1'b0, "after_rst");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
